// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces the
// lowest pressed column of the active row, and emits one code pulse per press.
//
// state     | meaning
// S_SCAN    | strobing rows, checking columns once per row period
// S_DEBOUNCE| candidate key found, counting consecutive low samples
// S_HELD    | key accepted, waiting for the column to go high
// S_RELEASE | counting consecutive high samples before resuming the scan
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] col_n_i,
    output logic [3:0] row_n_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_is_digit_o
);

    localparam int MAX_P = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]    col_meta_q, col_sync_q;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          digit_q, digit_d;
    logic          valid_q, valid_d;
    logic          col_low;
    logic [3:0]    mapped_code;

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col_n_i;
            col_sync_q <= col_meta_q;
        end
    end

    assign col_low     = ~col_sync_q[col_q];
    assign mapped_code = key_map(row_q, col_q);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        digit_d = digit_q;
        valid_d = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (col_sync_q == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d   = lowest_low(col_sync_q);
                        state_d = S_DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (col_low) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = '0;
                        code_d  = mapped_code;
                        digit_d = (mapped_code <= 4'd9);
                        valid_d = 1'b1;
                        state_d = S_HELD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // bounce: retry the same row from the start of its period
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_HELD: begin
                if (!col_low) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (col_low) begin
                    cnt_d   = '0;
                    state_d = S_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    row_d   = row_q + 2'd1;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            digit_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
        end
    end

    assign row_n_o        = ~(4'b0001 << row_q);
    assign key_code_o     = code_q;
    assign key_valid_o    = valid_q;
    assign key_is_digit_o = digit_q;

endmodule
